// File: rtl/fetch_queue_arbiter.sv
// Two-source round-robin arbiter in front of the single-entry fetch-packet queue.
// Zero-latency pass-through, grant lock under back-pressure, post-redirect discard window.
// Optional performance counters are built when FETCH_ARB_PERF_EN is defined.
module fetch_queue_arbiter #(
    parameter int PC_W         = 40,
    parameter int DATA_W       = 128,
    parameter int MASK_W       = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,

    input  logic              in0_valid_i,
    output logic              in0_ready_o,
    input  logic [PC_W-1:0]   in0_pc_i,
    input  logic [DATA_W-1:0] in0_data_i,
    input  logic [MASK_W-1:0] in0_mask_i,
    input  logic              in0_xcpt_pf_i,
    input  logic              in0_xcpt_ae_i,

    input  logic              in1_valid_i,
    output logic              in1_ready_o,
    input  logic [PC_W-1:0]   in1_pc_i,
    input  logic [DATA_W-1:0] in1_data_i,
    input  logic [MASK_W-1:0] in1_mask_i,
    input  logic              in1_xcpt_pf_i,
    input  logic              in1_xcpt_ae_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [MASK_W-1:0] out_mask_o,
    output logic              out_xcpt_pf_o,
    output logic              out_xcpt_ae_o,
    output logic              out_src_o
`ifdef FETCH_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_discard_o
`endif
);

    localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             lock_sel_q, lock_sel_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic sel;
    logic sel_valid;
    logic discard;
    logic handshake;

    // A locked grant ignores rr_ptr and the other source until it completes.
    always_comb begin
        if (state_q == ST_LOCKED)
            sel = lock_sel_q;
        else if (in0_valid_i && in1_valid_i)
            sel = rr_ptr_q;
        else
            sel = in1_valid_i;
    end

    assign sel_valid = sel ? in1_valid_i : in0_valid_i;
    assign discard   = flush_i || (state_q == ST_FLUSH);
    assign handshake = out_valid_o && out_ready_i;

    assign out_valid_o = !reset && !discard && sel_valid;
    assign in0_ready_o = !reset && (discard || (!sel && out_ready_i));
    assign in1_ready_o = !reset && (discard || ( sel && out_ready_i));
    assign out_src_o   = !reset && sel;

    assign out_pc_o      = sel ? in1_pc_i      : in0_pc_i;
    assign out_data_o    = sel ? in1_data_i    : in0_data_i;
    assign out_mask_o    = sel ? in1_mask_i    : in0_mask_i;
    assign out_xcpt_pf_o = sel ? in1_xcpt_pf_i : in0_xcpt_pf_i;
    assign out_xcpt_ae_o = sel ? in1_xcpt_ae_i : in0_xcpt_ae_i;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_sel_d  = lock_sel_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_i) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = CNT_LOAD;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (flush_cnt_q == '0)
                        state_d = ST_RUN;
                    else
                        flush_cnt_d = flush_cnt_q - 1'b1;
                end
                ST_LOCKED: begin
                    if (handshake) begin
                        rr_ptr_d = !lock_sel_q;
                        state_d  = ST_RUN;
                    end else if (!sel_valid) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (handshake) begin
                        rr_ptr_d = !sel;
                    end else if (out_valid_o) begin
                        lock_sel_d = sel;
                        state_d    = ST_LOCKED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            rr_ptr_q    <= 1'b0;
            lock_sel_q  <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_sel_q  <= lock_sel_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef FETCH_ARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant1_q, perf_discard_q;
    logic        discard_evt;

    assign discard_evt = discard && (in0_valid_i || in1_valid_i);

    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant0_q  <= '0;
            perf_grant1_q  <= '0;
            perf_discard_q <= '0;
        end else begin
            if (handshake && !sel && (perf_grant0_q != '1))
                perf_grant0_q <= perf_grant0_q + 32'd1;
            if (handshake && sel && (perf_grant1_q != '1))
                perf_grant1_q <= perf_grant1_q + 32'd1;
            if (discard_evt && (perf_discard_q != '1))
                perf_discard_q <= perf_discard_q + 32'd1;
        end
    end

    assign perf_grant0_o  = perf_grant0_q;
    assign perf_grant1_o  = perf_grant1_q;
    assign perf_discard_o = perf_discard_q;
`endif

endmodule

// File: tb/tb_fetch_queue_arbiter.sv
// Self-checking bench for fetch_queue_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_fetch_queue_arbiter;

    localparam int PC_W         = 40;
    localparam int DATA_W       = 128;
    localparam int MASK_W       = 8;
    localparam int FLUSH_CYCLES = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, flush, out_ready;
    logic              v    [2];
    logic [PC_W-1:0]   pc   [2];
    logic [DATA_W-1:0] data [2];
    logic [MASK_W-1:0] mask [2];
    logic              pf   [2];
    logic              ae   [2];

    logic              r0, r1, o_valid, o_pf, o_ae, o_src;
    logic [PC_W-1:0]   o_pc;
    logic [DATA_W-1:0] o_data;
    logic [MASK_W-1:0] o_mask;
`ifdef FETCH_ARB_PERF_EN
    logic [31:0]       pg0, pg1, pdis;
`endif

    fetch_queue_arbiter #(
        .PC_W(PC_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .flush_i(flush),
        .in0_valid_i(v[0]), .in0_ready_o(r0), .in0_pc_i(pc[0]), .in0_data_i(data[0]),
        .in0_mask_i(mask[0]), .in0_xcpt_pf_i(pf[0]), .in0_xcpt_ae_i(ae[0]),
        .in1_valid_i(v[1]), .in1_ready_o(r1), .in1_pc_i(pc[1]), .in1_data_i(data[1]),
        .in1_mask_i(mask[1]), .in1_xcpt_pf_i(pf[1]), .in1_xcpt_ae_i(ae[1]),
        .out_valid_o(o_valid), .out_ready_i(out_ready), .out_pc_o(o_pc), .out_data_o(o_data),
        .out_mask_o(o_mask), .out_xcpt_pf_o(o_pf), .out_xcpt_ae_o(o_ae), .out_src_o(o_src)
`ifdef FETCH_ARB_PERF_EN
        , .perf_grant0_o(pg0), .perf_grant1_o(pg1), .perf_discard_o(pdis)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: favoured source, held grant (-1 = none), discard cycles left.
    int m_rr, m_held, m_left;
    logic acc [2];
    logic obs_valid, obs_src, obs_r0, obs_r1;
    logic [PC_W-1:0] obs_pc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        bit disc, ev;
        int g;
        @(negedge clock);
        obs_valid = o_valid; obs_src = o_src; obs_pc = o_pc; obs_r0 = r0; obs_r1 = r1;
        disc = 1'b0; ev = 1'b0; g = 0;
        if (reset) begin
            chk("rst_valid", 128'(o_valid), 128'(0));
            chk("rst_r0", 128'(r0), 128'(0));
            chk("rst_r1", 128'(r1), 128'(0));
            chk("rst_src", 128'(o_src), 128'(0));
        end else begin
            disc = flush || (m_left > 0);
            if (m_held >= 0)        g = m_held;
            else if (v[0] && v[1])  g = m_rr;
            else                    g = v[1] ? 1 : 0;
            ev = !disc && v[g];
            chk("valid", 128'(o_valid), 128'(ev));
            if (disc) begin
                chk("disc_r0", 128'(r0), 128'(1));
                chk("disc_r1", 128'(r1), 128'(1));
            end else if (ev) begin
                chk("src", 128'(o_src), 128'(g));
                chk("pc", 128'(o_pc), 128'(pc[g]));
                chk("data", 128'(o_data), 128'(data[g]));
                chk("mask", 128'(o_mask), 128'(mask[g]));
                chk("xcpt", 128'({o_pf, o_ae}), 128'({pf[g], ae[g]}));
                chk("rdy_sel", 128'(g ? r1 : r0), 128'(out_ready));
                chk("rdy_other", 128'(g ? r0 : r1), 128'(0));
            end
        end
        for (int s = 0; s < 2; s++)
            acc[s] = !reset && v[s] && (disc || (ev && g == s && out_ready));
        @(posedge clock);
        if (reset) begin
            m_rr = 0; m_held = -1; m_left = 0;
        end else if (flush) begin
            m_left = FLUSH_CYCLES; m_held = -1;
        end else if (m_left > 0) begin
            m_left--;
        end else if (ev && out_ready) begin
            m_rr = 1 - g; m_held = -1;
        end else if (ev) begin
            m_held = g;
        end else begin
            m_held = -1;
        end
        #1;
    endtask

    task automatic set_src(input int s, input logic val, input logic [PC_W-1:0] p);
        v[s] = val; pc[s] = p;
        data[s] = {$urandom, $urandom, $urandom, $urandom};
        mask[s] = MASK_W'($urandom); pf[s] = 1'($urandom); ae[s] = 1'($urandom);
    endtask

    task automatic rand_inputs();
        for (int s = 0; s < 2; s++)
            if (!v[s] || acc[s] || $urandom_range(0, 99) < 3)
                set_src(s, $urandom_range(0, 99) < 65, PC_W'({$urandom, $urandom}));
        out_ready = $urandom_range(0, 99) < 60;
        flush     = $urandom_range(0, 99) < 7;
        reset     = $urandom_range(0, 199) == 0;
    endtask

    initial begin
        m_rr = 0; m_held = -1; m_left = 0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_src(0, 1'b1, 40'h1000);
        set_src(1, 1'b1, 40'h2000);
        repeat (3) step();

        // single src0 beat right after reset
        reset = 1'b0;
        set_src(0, 1'b1, 40'h80000000);
        set_src(1, 1'b0, 40'h0);
        step();
        chk("tp1_valid", 128'(obs_valid), 128'(1));
        chk("tp1_pc", 128'(obs_pc), 128'(40'h80000000));
        chk("tp1_src", 128'(obs_src), 128'(0));
        chk("tp1_r0", 128'(obs_r0), 128'(1));
        // src1 alone brings rr back to favouring src0
        v[0] = 1'b0; v[1] = 1'b1;
        step();

        // alternation
        v[0] = 1'b1; v[1] = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_src", 128'(obs_src), 128'(i % 2));
        end

        // back-pressure lock on src0
        out_ready = 1'b0;
        set_src(0, 1'b1, 40'h80001000);
        for (int i = 0; i < 3; i++) begin
            pc[1] = 40'h90000000 + PC_W'(i * 4);
            step();
            chk("lock_src", 128'(obs_src), 128'(0));
            chk("lock_pc", 128'(obs_pc), 128'(40'h80001000));
            chk("lock_r1", 128'(obs_r1), 128'(0));
        end
        out_ready = 1'b1;
        step();
        chk("lock_hs_src", 128'(obs_src), 128'(0));

        // src1 locked, then flush
        out_ready = 1'b0;
        set_src(0, 1'b1, 40'h3000);
        step();
        chk("next_src1", 128'(obs_src), 128'(1));
        step();
        flush = 1'b1;
        step();
        chk("fl_valid", 128'(obs_valid), 128'(0));
        chk("fl_r0", 128'(obs_r0), 128'(1));
        chk("fl_r1", 128'(obs_r1), 128'(1));
        flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_window", 128'(obs_valid), 128'(i == 2));
        end
        chk("fl_resume_src", 128'(obs_src), 128'(1));

        // flush held for three cycles
        flush = 1'b1;
        repeat (3) step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flhold_window", 128'(obs_valid), 128'(i == 2));
        end

`ifdef FETCH_ARB_PERF_EN
        reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b1;
        v[0] = 1'b1; v[1] = 1'b0;
        repeat (5) step();
        v[0] = 1'b0; v[1] = 1'b1;
        repeat (3) step();
        v[0] = 1'b1; v[1] = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        v[0] = 1'b0;
        step();
        chk("perf_grant0", 128'(pg0), 128'(5));
        chk("perf_grant1", 128'(pg1), 128'(3));
        chk("perf_discard", 128'(pdis), 128'(3));
`endif

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
